life_step: RTL

Generation engine for the 16×16 Game of Life board. It accepts a seed map from the random-map initializer, holds it as the current generation, and on each `start` request computes the next generation one row per clock. Results are published as a flat map to the display stage. Population and extinction status are reported once per generation.

---
 rtl/life_pkg.sv | 34 +++
 rtl/life_row_next.sv | 34 +++
 rtl/life_step.sv | 119 +++++++++++
 3 files changed

// File: rtl/life_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | life_pkg                                                             |
// | Shared board geometry, FSM encoding and helpers for life_step.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package life_pkg;

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int CELLS = ROWS * COLS;
    localparam int ROW_W = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROW    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic int cell_idx(input int r, input int c);
        return r * COLS + c;
    endfunction

    function automatic logic [4:0] popcount_row(input logic [COLS-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < COLS; i++) begin
            n = n + {4'b0000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/life_row_next.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | life_row_next                                                        |
// | Combinational next-generation rule for one board row.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module life_row_next
    import life_pkg::*;
(
    input  logic [COLS-1:0] above,
    input  logic [COLS-1:0] cur,
    input  logic [COLS-1:0] below,
    output logic [COLS-1:0] next_row
);

    // One dead column on each side so the edge columns see dead neighbours.
    logic [COLS+1:0] w_above_p;
    logic [COLS+1:0] w_cur_p;
    logic [COLS+1:0] w_below_p;

    assign w_above_p = {1'b0, above, 1'b0};
    assign w_cur_p   = {1'b0, cur,   1'b0};
    assign w_below_p = {1'b0, below, 1'b0};

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [3:0] w_cnt;
        assign w_cnt = {3'b000, w_above_p[c]} + {3'b000, w_above_p[c+1]} + {3'b000, w_above_p[c+2]}
                     + {3'b000, w_cur_p[c]}                                + {3'b000, w_cur_p[c+2]}
                     + {3'b000, w_below_p[c]} + {3'b000, w_below_p[c+1]} + {3'b000, w_below_p[c+2]};
        assign next_row[c] = (w_cnt == 4'd3) || (cur[c] && (w_cnt == 4'd2));
    end

endmodule
`default_nettype wire

// File: rtl/life_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | life_step                                                            |
// | 16x16 Game of Life generation engine, one row per clock.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module life_step
    import life_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CELLS-1:0] seed_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CELLS-1:0] map_out,
    output logic [15:0]      gen_count,
    output logic [8:0]       alive_count,
    output logic             extinct
);

    localparam logic [ROW_W-1:0] c_last_row = ROW_W'(ROWS - 1);

    state_t           r_state;
    logic [ROW_W-1:0] r_row;
    logic [CELLS-1:0] r_map;
    logic [CELLS-1:0] r_shadow;
    logic [8:0]       r_acc;
    logic [8:0]       r_alive;
    logic [15:0]      r_gen;
    logic             r_extinct;
    logic             r_busy;
    logic             r_done;

    logic [ROW_W-1:0] w_row_up;
    logic [ROW_W-1:0] w_row_dn;
    logic [COLS-1:0]  w_above;
    logic [COLS-1:0]  w_cur;
    logic [COLS-1:0]  w_below;
    logic [COLS-1:0]  w_next;

    // Neighbour row indices wrap in 4 bits; the off-board rows are forced to zero.
    assign w_row_up = r_row - 1'b1;
    assign w_row_dn = r_row + 1'b1;
    assign w_above  = (r_row == '0)         ? '0 : r_map[cell_idx(int'(w_row_up), 0) +: COLS];
    assign w_cur    = r_map[cell_idx(int'(r_row), 0) +: COLS];
    assign w_below  = (r_row == c_last_row) ? '0 : r_map[cell_idx(int'(w_row_dn), 0) +: COLS];

    life_row_next u_row_next (
        .above    (w_above),
        .cur      (w_cur),
        .below    (w_below),
        .next_row (w_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_map     <= '0;
            r_shadow  <= '0;
            r_acc     <= '0;
            r_alive   <= '0;
            r_gen     <= '0;
            r_extinct <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_map     <= seed_in;
                        r_gen     <= '0;
                        r_alive   <= '0;
                        r_extinct <= 1'b0;
                    end else if (start) begin
                        r_state <= ROW;
                        r_row   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ROW: begin
                    r_shadow[cell_idx(int'(r_row), 0) +: COLS] <= w_next;
                    r_acc <= r_acc + {4'b0000, popcount_row(w_next)};
                    if (r_row == c_last_row) begin
                        r_state <= COMMIT;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                COMMIT: begin
                    r_map     <= r_shadow;
                    r_alive   <= r_acc;
                    r_extinct <= (r_acc == '0);
                    if (r_gen != 16'hFFFF) begin
                        r_gen <= r_gen + 16'd1;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_row   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign map_out     = r_map;
    assign gen_count   = r_gen;
    assign alive_count = r_alive;
    assign extinct     = r_extinct;

endmodule
`default_nettype wire
